// File: rtl/avalon_mm_responder_if.sv
// Avalon-MM bus bundle between a master and the avalon_mm_responder memory.
//
// Handshake: a request (ChipEnable=1 with Write and/or Read) is accepted on
// a rising edge only while WaitRequest=0. While WaitRequest=1 the master holds
// the request unchanged. Read responses come back in order as one-cycle
// ReadDataValid strobes, and the master cannot stall them.
interface avalon_mm_responder_if;
  logic        Avalon_ChipEnable;
  logic [24:0] Avalon_Address;
  logic [1:0]  Avalon_ByteEnable;
  logic        Avalon_WaitRequest;
  logic [15:0] Avalon_WriteData;
  logic        Avalon_Write;
  logic        Avalon_Read;
  logic [15:0] Avalon_ReadData;
  logic        Avalon_ReadDataValid;

  modport master (
    output Avalon_ChipEnable, Avalon_Address, Avalon_ByteEnable,
           Avalon_WriteData, Avalon_Write, Avalon_Read,
    input  Avalon_WaitRequest, Avalon_ReadData, Avalon_ReadDataValid
  );

  modport slave (
    input  Avalon_ChipEnable, Avalon_Address, Avalon_ByteEnable,
           Avalon_WriteData, Avalon_Write, Avalon_Read,
    output Avalon_WaitRequest, Avalon_ReadData, Avalon_ReadDataValid
  );
endinterface

// File: rtl/avalon_mm_responder.sv
// Avalon-MM memory responder: a 16-bit word memory with byte-lane writes,
// fixed-latency pipelined reads, a limit on reads in flight, and periodic
// refresh stalls that emulate an SDRAM-like target. A request that carries
// both Write and Read performs the write only and latches a sticky Error.
module avalon_mm_responder #(
  parameter int DEPTH_LOG2     = 10,
  parameter int LATENCY        = 2,
  parameter int MAX_PENDING    = 2,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  avalon_mm_responder_if.slave  bus,
  output logic                  Error
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int RCW   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int RLW   = $clog2(REFRESH_CYCLES + 1);

  logic                  rst_q;
  logic [2:0]            pend_q, pend_d;
  logic                  err_q, err_d;
  logic [RCW-1:0]        rcnt_q, rcnt_d;
  logic [RLW-1:0]        rleft_q, rleft_d;
  logic [LATENCY-1:0]    vld_q;
  logic [15:0]           dat_q [LATENCY];
  logic [15:0]           mem [WORDS];

  logic                  wait_req;
  logic                  acc, wr_acc, rd_acc, retire;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0]           rd_word;

  // Stall while coming out of reset, refreshing, or at the in-flight limit.
  assign wait_req = rst_q | (rleft_q != '0) | (pend_q == 3'(MAX_PENDING));
  assign bus.Avalon_WaitRequest = wait_req;

  assign acc    = bus.Avalon_ChipEnable & (bus.Avalon_Write | bus.Avalon_Read) & ~wait_req;
  assign wr_acc = acc & bus.Avalon_Write;
  // A combined write+read is treated as a write; its read half is dropped.
  assign rd_acc = acc & bus.Avalon_Read & ~bus.Avalon_Write;

  assign in_range = ~|(bus.Avalon_Address >> DEPTH_LOG2);
  assign idx      = bus.Avalon_Address[DEPTH_LOG2-1:0];
  assign rd_word  = in_range ? mem[idx] : 16'h0000;

  // A read retires on the edge that moves it into the output stage, so the
  // slot is freed while its ReadDataValid is being presented.
  generate
    if (LATENCY == 1) begin : g_ret_l1
      assign retire = rd_acc;
    end else begin : g_ret_ln
      assign retire = vld_q[LATENCY-2];
    end
  endgenerate

  assign bus.Avalon_ReadDataValid = vld_q[LATENCY-1];
  assign bus.Avalon_ReadData      = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : 16'h0000;
  assign Error                    = err_q;

  // Memory array: byte-lane writes, no reset so contents survive Reset.
  always_ff @(posedge Clk) begin
    if (wr_acc && in_range) begin
      if (bus.Avalon_ByteEnable[0]) mem[idx][7:0]  <= bus.Avalon_WriteData[7:0];
      if (bus.Avalon_ByteEnable[1]) mem[idx][15:8] <= bus.Avalon_WriteData[15:8];
    end
  end

  // Next-state for the in-flight counter, error flag and refresh timers.
  always_comb begin
    pend_d  = pend_q;
    err_d   = err_q;
    rcnt_d  = rcnt_q;
    rleft_d = rleft_q;
    case ({rd_acc, retire})
      2'b10:   pend_d = pend_q + 3'd1;
      2'b01:   pend_d = pend_q - 3'd1;
      default: pend_d = pend_q;
    endcase
    if (acc && bus.Avalon_Write && bus.Avalon_Read) err_d = 1'b1;
    if (!rst_q) begin
      if (rleft_q != '0) rleft_d = rleft_q - 1'b1;
      if (rcnt_q == RCW'(REFRESH_PERIOD - 1)) begin
        rcnt_d  = '0;
        rleft_d = RLW'(REFRESH_CYCLES);
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  // Control registers; rst_q keeps WaitRequest high until the first edge after Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rst_q   <= 1'b1;
      pend_q  <= '0;
      err_q   <= 1'b0;
      rcnt_q  <= '0;
      rleft_q <= '0;
    end else begin
      rst_q   <= 1'b0;
      pend_q  <= pend_d;
      err_q   <= err_d;
      rcnt_q  <= rcnt_d;
      rleft_q <= rleft_d;
    end
  end

  // Read pipeline: stage 0 captures the word at acceptance, the last stage is the output.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= 16'h0000;
    end else begin
      vld_q[0] <= rd_acc;
      dat_q[0] <= rd_acc ? rd_word : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_avalon_mm_responder.sv
// Bench for avalon_mm_responder: a default instance (LATENCY=2, MAX_PENDING=2)
// and a tight instance (LATENCY=3, MAX_PENDING=1). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_avalon_mm_responder;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic err0, err1;
  int   cyc = -1;
  int   tests = 0;
  int   fails = 0;

  always #5 Clk = ~Clk;

  avalon_mm_responder_if bus0 ();
  avalon_mm_responder_if bus1 ();

  avalon_mm_responder #(
    .DEPTH_LOG2(10), .LATENCY(2), .MAX_PENDING(2),
    .REFRESH_PERIOD(780), .REFRESH_CYCLES(8)
  ) u_dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0), .Error(err0));

  avalon_mm_responder #(
    .DEPTH_LOG2(10), .LATENCY(3), .MAX_PENDING(1),
    .REFRESH_PERIOD(780), .REFRESH_CYCLES(8)
  ) u_dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1), .Error(err1));

  // cyc = index of the last rising edge since Reset fell (0 = first edge).
  always @(posedge Clk) cyc <= Reset ? -1 : cyc + 1;

  // Scoreboard: expected read data and the cyc value at which it must appear.
  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];
  int          cyc0_q[$];
  int          cyc1_q[$];

  typedef struct {
    logic        we;
    logic        rd;
    logic [24:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitors.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus0.Avalon_ReadDataValid) begin
        if (exp0_q.size() == 0) check("dut0_unexpected_valid", 1, 0);
        else begin
          check("dut0_rdata", bus0.Avalon_ReadData, exp0_q.pop_front());
          check("dut0_latency", cyc, cyc0_q.pop_front());
        end
      end else begin
        check("dut0_idle_rdata_zero", bus0.Avalon_ReadData, 0);
      end
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus1.Avalon_ReadDataValid) begin
        if (exp1_q.size() == 0) check("dut1_unexpected_valid", 1, 0);
        else begin
          check("dut1_rdata", bus1.Avalon_ReadData, exp1_q.pop_front());
          check("dut1_latency", cyc, cyc1_q.pop_front());
        end
      end else begin
        check("dut1_idle_rdata_zero", bus1.Avalon_ReadData, 0);
      end
    end
  end

  function automatic logic wr_of(input int sel);
    return (sel != 0) ? bus1.Avalon_WaitRequest : bus0.Avalon_WaitRequest;
  endfunction

  task automatic drive(input int sel, input logic ce, input logic we, input logic rd,
                       input logic [24:0] addr, input logic [1:0] be, input logic [15:0] wd);
    if (sel == 0) begin
      bus0.Avalon_ChipEnable = ce; bus0.Avalon_Write = we; bus0.Avalon_Read = rd;
      bus0.Avalon_Address = addr; bus0.Avalon_ByteEnable = be; bus0.Avalon_WriteData = wd;
    end else begin
      bus1.Avalon_ChipEnable = ce; bus1.Avalon_Write = we; bus1.Avalon_Read = rd;
      bus1.Avalon_Address = addr; bus1.Avalon_ByteEnable = be; bus1.Avalon_WriteData = wd;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 1'b0, 25'h0, 2'b00, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 25'h0, 2'b00, 16'h0);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic do_op(input int sel, input logic we, input logic rd, input logic [24:0] addr,
                       input logic [1:0] be, input logic [15:0] wd, input logic [15:0] exp_rd,
                       output int waits, output int acc);
    drive(sel, 1'b1, we, rd, addr, be, wd);
    waits = 0;
    while (wr_of(sel) && waits < 50) begin
      @(negedge Clk);
      waits++;
    end
    if (waits >= 50) check("accept_timeout", 1, 0);
    acc = cyc + 1;
    if (rd && !we) begin
      if (sel == 0) begin exp0_q.push_back(exp_rd); cyc0_q.push_back(acc + 1); end
      else          begin exp1_q.push_back(exp_rd); cyc1_q.push_back(acc + 2); end
    end
    @(negedge Clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the first post-reset edge.
  task automatic do_reset();
    #2 Reset = 1'b1;
    idle_all();
    repeat (2) @(negedge Clk);
    check("rst_waitreq0", bus0.Avalon_WaitRequest, 1);
    check("rst_waitreq1", bus1.Avalon_WaitRequest, 1);
    check("rst_valid0", bus0.Avalon_ReadDataValid, 0);
    check("rst_valid1", bus1.Avalon_ReadDataValid, 0);
    check("rst_rdata0", bus0.Avalon_ReadData, 0);
    check("rst_error0", err0, 0);
    check("rst_error1", err1, 0);
    exp0_q.delete(); cyc0_q.delete();
    exp1_q.delete(); cyc1_q.delete();
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_waitreq0", bus0.Avalon_WaitRequest, 0);
    check("post_rst_waitreq1", bus1.Avalon_WaitRequest, 0);
  endtask

  initial begin
    int w, a;
    int accs[4];
    logic [24:0] b2b_addr[4];
    logic [15:0] b2b_data[4];

    vecs[0]  = '{1'b1, 1'b0, 25'h5,       2'b11, 16'h1234, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 25'h5,       2'b10, 16'hAB00, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 25'h5,       2'b11, 16'h0000, 16'hAB34};
    vecs[3]  = '{1'b1, 1'b0, 25'h6,       2'b11, 16'hFFFF, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 25'h6,       2'b01, 16'h12CD, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 25'h6,       2'b11, 16'h0000, 16'hFFCD};
    vecs[6]  = '{1'b1, 1'b0, 25'h6,       2'b00, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 25'h6,       2'b11, 16'h0000, 16'hFFCD};
    vecs[8]  = '{1'b1, 1'b0, 25'h3FF,     2'b11, 16'hBEEF, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 25'h3FF,     2'b11, 16'h0000, 16'hBEEF};
    vecs[10] = '{1'b1, 1'b0, 25'h0,       2'b11, 16'h0F0F, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 25'h400,     2'b11, 16'hDEAD, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 25'h0,       2'b11, 16'h0000, 16'h0F0F};
    vecs[13] = '{1'b0, 1'b1, 25'h400,     2'b11, 16'h0000, 16'h0000};
    vecs[14] = '{1'b0, 1'b1, 25'h1000000, 2'b11, 16'h0000, 16'h0000};
    vecs[15] = '{1'b1, 1'b0, 25'h5,       2'b11, 16'h7777, 16'h0000};
    vecs[16] = '{1'b0, 1'b1, 25'h5,       2'b11, 16'h0000, 16'h7777};

    b2b_addr = '{25'h5, 25'h6, 25'h3FF, 25'h0};
    b2b_data = '{16'h7777, 16'hFFCD, 16'hBEEF, 16'h0F0F};

    idle_all();
    repeat (2) @(negedge Clk);
    do_reset();

    // Table-driven single transactions, issued back to back.
    for (int i = 0; i < 17; i++)
      do_op(0, vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wd, vecs[i].exp, w, a);
    idle_all();
    repeat (4) @(negedge Clk);

    // Four consecutive reads: no stall, consecutive acceptance edges.
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1'b0, 1'b1, b2b_addr[i], 2'b11, 16'h0, b2b_data[i], w, accs[i]);
      check("b2b_no_wait", w, 0);
    end
    idle_all();
    for (int i = 1; i < 4; i++) check("b2b_consecutive", accs[i], accs[0] + i);
    repeat (4) @(negedge Clk);

    // Write and read together: write happens, read dropped, Error sticks.
    check("error_before", err0, 0);
    do_op(0, 1'b1, 1'b1, 25'h3, 2'b11, 16'h5555, 16'h0, w, a);
    idle_all();
    repeat (4) @(negedge Clk);
    check("error_set", err0, 1);
    do_op(0, 1'b0, 1'b1, 25'h3, 2'b11, 16'h0, 16'h5555, w, a);
    idle_all();
    repeat (4) @(negedge Clk);
    check("error_sticky", err0, 1);
    do_reset();
    check("error_cleared", err0, 0);
    do_op(0, 1'b0, 1'b1, 25'h3, 2'b11, 16'h0, 16'h5555, w, a);
    idle_all();
    repeat (4) @(negedge Clk);

    // Reset with one read in flight: its response must never appear.
    do_op(0, 1'b0, 1'b1, 25'h5, 2'b11, 16'h0, 16'h7777, w, a);
    do_reset();
    repeat (4) begin
      @(negedge Clk);
      check("no_valid_after_reset", bus0.Avalon_ReadDataValid, 0);
    end

    // Tight instance: one read in flight, three-cycle latency.
    for (int i = 0; i < 6; i++)
      do_op(1, 1'b1, 1'b0, 25'(i + 1), 2'b11, 16'hA000 | 16'(i), 16'h0, w, a);
    for (int i = 0; i < 6; i++) begin
      do_op(1, 1'b0, 1'b1, 25'(i + 1), 2'b11, 16'h0, 16'hA000 | 16'(i), w, a);
      check("mp1_waits", w, (i == 0) ? 0 : 2);
    end
    idle_all();
    repeat (6) @(negedge Clk);

    // Refresh: wrap at edge 780, stall for edges 780..787 on the default instance.
    do_reset();
    while (cyc < 770) @(negedge Clk);
    while (cyc < 779) begin
      check("pre_refresh_waitreq", bus0.Avalon_WaitRequest, 0);
      @(negedge Clk);
    end
    do_op(0, 1'b0, 1'b1, 25'h5, 2'b11, 16'h0, 16'h7777, w, a);
    check("refresh_first_wait", w, 0);
    check("refresh_first_acc", a, 780);
    do_op(0, 1'b0, 1'b1, 25'h6, 2'b11, 16'h0, 16'hFFCD, w, a);
    check("refresh_stall_len", w, 8);
    check("refresh_held_acc", a, 789);
    idle_all();
    repeat (5) @(negedge Clk);

    check("dut0_drained", exp0_q.size(), 0);
    check("dut1_drained", exp1_q.size(), 0);
    check("dut1_no_error", err1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
